// File: rtl/jogo_pkg.sv
// rtl/jogo_pkg.sv - shared encodings and helpers for the tic-tac-toe move front end
package jogo_pkg;

  localparam int N_BOTOES       = 9;
  localparam int LARGURA_JOGADA = 4;

  typedef enum logic [1:0] {
    st_aguarda_soltar = 2'd0,
    st_ocioso         = 2'd1,
    st_estabilizando  = 2'd2,
    st_emite          = 2'd3
  } estado_t;

  // True when exactly one button is down
  function automatic logic eh_one_hot(input logic [N_BOTOES-1:0] v);
    return (v != '0) && ((v & (v - 9'd1)) == '0);
  endfunction

  // Index of the highest set bit; only meaningful for one-hot inputs
  function automatic logic [LARGURA_JOGADA-1:0] codifica(input logic [N_BOTOES-1:0] v);
    logic [LARGURA_JOGADA-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_BOTOES; i++) begin
      if (v[i]) idx = LARGURA_JOGADA'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/detector_jogada_if.sv
// rtl/detector_jogada_if.sv - tem_jogada handshake between move detector and control unit
interface detector_jogada_if;

  logic                                jogar_macro;
  logic                                jogar_micro;
  logic                                tem_jogada;
  logic                                jogada_invalida;
  logic [jogo_pkg::LARGURA_JOGADA-1:0] jogada;

  // Producer side: the move detector
  modport master (
    input  jogar_macro,
    input  jogar_micro,
    output tem_jogada,
    output jogada_invalida,
    output jogada
  );

  // Consumer side: the game control unit
  modport slave (
    output jogar_macro,
    output jogar_micro,
    input  tem_jogada,
    input  jogada_invalida,
    input  jogada
  );

endinterface

// File: rtl/sincronizador_2ff.sv
// rtl/sincronizador_2ff.sv - two-flop synchroniser for asynchronous inputs
module sincronizador_2ff #(
  parameter int LARGURA = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [LARGURA-1:0] d,
  output logic [LARGURA-1:0] q
);

  logic [LARGURA-1:0] meta;

  // Two-stage capture to settle metastability before the logic sees the pins
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/detector_jogada.sv
// rtl/detector_jogada.sv - debounced, one-hot-checked move detector for the control unit
module detector_jogada
  import jogo_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 zera,
  input  logic [N_BOTOES-1:0]  botoes,
  detector_jogada_if.master    jogo,
  output logic [3:0]           db_estado
);

  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);
  localparam logic [CW-1:0] CNT_SAT = '1;

  logic [N_BOTOES-1:0]       botoes_s;
  logic                      habilita;

  estado_t                   estado, estado_prox;
  logic [CW-1:0]             cnt, cnt_prox;
  logic [N_BOTOES-1:0]       snapshot, snapshot_prox;
  logic [LARGURA_JOGADA-1:0] jogada_r, jogada_prox;

  sincronizador_2ff #(.LARGURA(N_BOTOES)) u_sinc (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (botoes),
    .q       (botoes_s)
  );

  assign habilita = jogo.jogar_macro | jogo.jogar_micro;

  // State, debounce counter, captured pattern and held move
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado   <= st_aguarda_soltar;
      cnt      <= '0;
      snapshot <= '0;
      jogada_r <= '0;
    end else begin
      estado   <= estado_prox;
      cnt      <= cnt_prox;
      snapshot <= snapshot_prox;
      jogada_r <= jogada_prox;
    end
  end

  // Next-state logic; zera overrides everything, counter saturates instead of wrapping
  always_comb begin
    estado_prox   = estado;
    cnt_prox      = cnt;
    snapshot_prox = snapshot;
    jogada_prox   = jogada_r;

    if (zera) begin
      estado_prox = st_aguarda_soltar;
      cnt_prox    = '0;
      jogada_prox = '0;
    end else begin
      unique case (estado)
        st_aguarda_soltar: begin
          if (botoes_s != '0) begin
            cnt_prox = '0;
          end else if (cnt == CNT_MAX) begin
            estado_prox = st_ocioso;
          end else begin
            cnt_prox = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
          end
        end
        st_ocioso: begin
          if (habilita && (botoes_s != '0)) begin
            snapshot_prox = botoes_s;
            cnt_prox      = '0;
            estado_prox   = st_estabilizando;
          end
        end
        st_estabilizando: begin
          if (!habilita) begin
            estado_prox = st_aguarda_soltar;
            cnt_prox    = '0;
          end else if (botoes_s == '0) begin
            estado_prox = st_ocioso;
          end else if (botoes_s != snapshot) begin
            snapshot_prox = botoes_s;
            cnt_prox      = '0;
          end else if (cnt == CNT_MAX) begin
            estado_prox = st_emite;
            if (eh_one_hot(snapshot)) jogada_prox = codifica(snapshot);
          end else begin
            cnt_prox = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
          end
        end
        st_emite: begin
          estado_prox = st_aguarda_soltar;
          cnt_prox    = '0;
        end
        default: begin
          estado_prox = st_aguarda_soltar;
          cnt_prox    = '0;
        end
      endcase
    end
  end

  // Moore outputs: pulses exist only in the single emite cycle
  always_comb begin
    jogo.tem_jogada      = (estado == st_emite) &&  eh_one_hot(snapshot);
    jogo.jogada_invalida = (estado == st_emite) && !eh_one_hot(snapshot);
    jogo.jogada          = jogada_r;
    db_estado            = 4'(estado);
  end

endmodule

// File: tb/tb_detector_jogada.sv
// tb/tb_detector_jogada.sv - scoreboard bench for detector_jogada with DEBOUNCE_CICLOS=4
module tb_detector_jogada;

  logic       clock;
  logic       reset_n;
  logic       zera;
  logic [8:0] botoes;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic       inv;
    logic [3:0] jog;
    int         cyc;
  } esperado_t;

  esperado_t fila[$];

  detector_jogada_if jogo_if ();

  detector_jogada #(.DEBOUNCE_CICLOS(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .zera      (zera),
    .botoes    (botoes),
    .jogo      (jogo_if),
    .db_estado (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic espera(input logic inv, input logic [3:0] jog, input int atraso);
    esperado_t e;
    e.inv = inv;
    e.jog = jog;
    e.cyc = cyc + atraso;
    fila.push_back(e);
  endtask

  // Compare every pulse against the oldest expected event
  always @(negedge clock) begin
    if (reset_n && (jogo_if.tem_jogada || jogo_if.jogada_invalida)) begin
      verifica("exclusivo", {31'd0, jogo_if.tem_jogada & jogo_if.jogada_invalida}, 32'd0);
      if (fila.size() == 0) begin
        verifica("pulso_inesperado", 32'd1, 32'd0);
      end else begin
        esperado_t e;
        e = fila.pop_front();
        verifica("tem_jogada", {31'd0, jogo_if.tem_jogada}, {31'd0, ~e.inv});
        verifica("jogada_invalida", {31'd0, jogo_if.jogada_invalida}, {31'd0, e.inv});
        verifica("jogada", {28'd0, jogo_if.jogada}, {28'd0, e.jog});
        verifica("ciclo", cyc, e.cyc);
      end
    end
  end

  initial begin
    reset_n             = 1'b0;
    zera                = 1'b0;
    botoes              = 9'h000;
    jogo_if.jogar_macro = 1'b0;
    jogo_if.jogar_micro = 1'b0;
    tick(2);
    verifica("rst_estado", {28'd0, db_estado}, 32'd0);
    verifica("rst_jogada", {28'd0, jogo_if.jogada}, 32'd0);
    verifica("rst_tem", {31'd0, jogo_if.tem_jogada}, 32'd0);
    verifica("rst_inv", {31'd0, jogo_if.jogada_invalida}, 32'd0);
    reset_n = 1'b1;
    tick(6);
    verifica("ocioso_inicial", {28'd0, db_estado}, 32'd1);

    // Clean press of position 4
    jogo_if.jogar_macro = 1'b1;
    botoes = 9'h010;
    espera(1'b0, 4'd4, 7);
    tick(12);
    verifica("s1_jogada", {28'd0, jogo_if.jogada}, 32'd4);
    verifica("s1_aguarda", {28'd0, db_estado}, 32'd0);
    botoes = 9'h000;
    tick(8);
    verifica("s1_ocioso", {28'd0, db_estado}, 32'd1);

    // Bouncing contact settles on position 4
    for (int k = 0; k < 4; k++) begin
      botoes = (k % 2 == 0) ? 9'h010 : 9'h000;
      tick(2);
    end
    botoes = 9'h010;
    espera(1'b0, 4'd4, 7);
    tick(12);
    botoes = 9'h000;
    tick(8);
    verifica("s2_ocioso", {28'd0, db_estado}, 32'd1);

    // Two keys at once during the micro window
    jogo_if.jogar_macro = 1'b0;
    jogo_if.jogar_micro = 1'b1;
    botoes = 9'h011;
    espera(1'b1, 4'd4, 7);
    tick(12);
    verifica("s3_jogada_mantida", {28'd0, jogo_if.jogada}, 32'd4);
    botoes = 9'h000;
    tick(8);

    // Button held across the end of one window into the next
    jogo_if.jogar_micro = 1'b0;
    jogo_if.jogar_macro = 1'b1;
    botoes = 9'h100;
    tick(4);
    verifica("s4_estab", {28'd0, db_estado}, 32'd2);
    jogo_if.jogar_macro = 1'b0;
    tick(1);
    jogo_if.jogar_micro = 1'b1;
    tick(10);
    verifica("s4_preso", {28'd0, db_estado}, 32'd0);
    botoes = 9'h000;
    tick(8);
    verifica("s4_ocioso", {28'd0, db_estado}, 32'd1);
    botoes = 9'h100;
    espera(1'b0, 4'd8, 7);
    tick(10);
    verifica("s4_jogada", {28'd0, jogo_if.jogada}, 32'd8);
    botoes = 9'h000;
    tick(8);

    // Press while disabled, then zera in the middle of debouncing
    jogo_if.jogar_micro = 1'b0;
    botoes = 9'h004;
    tick(6);
    verifica("s5_sem_habilita", {28'd0, db_estado}, 32'd1);
    jogo_if.jogar_macro = 1'b1;
    tick(1);
    verifica("s5_estab", {28'd0, db_estado}, 32'd2);
    zera = 1'b1;
    tick(1);
    zera = 1'b0;
    verifica("s5_zera_estado", {28'd0, db_estado}, 32'd0);
    verifica("s5_zera_jogada", {28'd0, jogo_if.jogada}, 32'd0);
    botoes = 9'h000;
    tick(8);
    verifica("s5_ocioso", {28'd0, db_estado}, 32'd1);

    // Asynchronous reset during the emite cycle
    botoes = 9'h002;
    repeat (7) @(posedge clock);
    #1;
    verifica("s6_emite", {28'd0, db_estado}, 32'd3);
    verifica("s6_tem", {31'd0, jogo_if.tem_jogada}, 32'd1);
    reset_n = 1'b0;
    #1;
    verifica("s6_rst_tem", {31'd0, jogo_if.tem_jogada}, 32'd0);
    verifica("s6_rst_estado", {28'd0, db_estado}, 32'd0);
    verifica("s6_rst_jogada", {28'd0, jogo_if.jogada}, 32'd0);
    botoes = 9'h000;
    tick(2);
    reset_n = 1'b1;
    tick(8);

    verifica("pendentes", fila.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/detector_jogada.md
# detector_jogada

Move-input front end for the ultimate tic-tac-toe game: the producer side of the `tem_jogada` handshake consumed by the game control unit. Synchronises and debounces the nine position buttons and accepts a press only while the control unit is asking for a move (`jogar_macro` or `jogar_micro`). A valid press emits a one-cycle `tem_jogada` pulse with the 4-bit encoded position; multi-key presses are rejected. After any accepted or rejected press, the block waits for full release before accepting another.

## Interface
- `DEBOUNCE_CICLOS`, default 50000: consecutive stable cycles required on press and on release; must be ≥1.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `zera` in 1: synchronous clear, driven by the control unit's `zeraEdge`.
- `jogar_macro` in 1: the control unit is waiting for a macro-board move.
- `jogar_micro` in 1: the control unit is waiting for a micro-board move.
- `botoes` in 9: raw active-high buttons; bit i is position i (0..8).
- `tem_jogada` out 1: one-cycle pulse when a valid move is accepted.
- `jogada` out 4: encoded position 0..8; held until the next valid move or until cleared.
- `jogada_invalida` out 1: one-cycle pulse when the debounced input is not one-hot.
- `db_estado` out 4: current state code, for debug.

## Operation
- `botoes` passes through a 2-flop synchroniser, giving `botoes_s`. All logic uses `botoes_s`. Define `habilita = jogar_macro | jogar_micro`.
- States:
  - `aguarda_soltar` = 0 (reset state)
  - `ocioso` = 1
  - `estabilizando` = 2
  - `emite` = 3
- Transitions from `aguarda_soltar`:
  - If `botoes_s` is nonzero, the counter resets to 0.
  - Otherwise the counter increments.
  - When the counter reaches `DEBOUNCE_CICLOS-1` with `botoes_s`==0, go to `ocioso`.
- Transitions from `ocioso`:
  - If `habilita` and `botoes_s`≠0: capture `snapshot<=botoes_s`, set counter to 0, go to `estabilizando`.
  - Otherwise stay in `ocioso`.
- Transitions from `estabilizando`, in priority order:
  - `habilita`=0: go to `aguarda_soltar` with the counter at 0.
  - `botoes_s`==0: go to `ocioso`.
  - `botoes_s`≠`snapshot`: re-capture the snapshot, counter to 0, stay.
  - Counter reaches `DEBOUNCE_CICLOS-1`: go to `emite`.
  - Otherwise increment the counter.
- `emite` lasts one cycle, then goes unconditionally to `aguarda_soltar` with the counter at 0.
- On the `estabilizando`→`emite` transition:
  - If `snapshot` is one-hot, `jogada` is loaded with the index of the set bit.
  - If not, `jogada` keeps its value.
- Outputs in `emite` (Moore):
  - `tem_jogada` = 1 when `snapshot` is one-hot.
  - `jogada_invalida` = 1 when it is not.
- `zera` has priority over all transitions. It forces `aguarda_soltar`, sets the counter to 0 and sets `jogada` to 0. The synchroniser is not cleared.
- `jogar_macro` and `jogar_micro` asserted together behave as `habilita`=1. The block does not distinguish the two; the control unit selects the destination register.
- The counter width is `$clog2(DEBOUNCE_CICLOS+1)`. It saturates and never wraps.

## Timing
- Reset values:
  - state `aguarda_soltar`
  - `tem_jogada`=0, `jogada_invalida`=0
  - `jogada`=4'd0
  - `db_estado`=4'd0
  - counter, `snapshot` and synchroniser all 0
- Latency:
  - A pin change at cycle p is visible on `botoes_s` at p+2.
  - A clean press stable from cycle p, with `habilita` high and state `ocioso`, gives `tem_jogada` high in cycle p+3+`DEBOUNCE_CICLOS`.
- `tem_jogada` and `jogada_invalida` are never high together, and each is high for exactly one cycle per press.
- A button held through a new `habilita` window produces no pulse until it has been released for `DEBOUNCE_CICLOS` cycles and pressed again.
- `jogada` is stable from the `tem_jogada` cycle onward, so the control unit may register it one cycle later (`registraR_*`).
- If `reset_n` is asserted mid-debounce, the pulse is aborted and all outputs return to their reset values immediately (asynchronously).

## Structure
- Shared package `jogo_pkg`:
  - state encodings
  - `N_BOTOES`=9
  - `LARGURA_JOGADA`=4
- Sub-module `sincronizador_2ff`: parameterised width, `clock`/`reset_n`, clears to 0.
- The one-hot check and index encoder are combinational functions in `jogo_pkg`.

## Test plan
All scenarios use `DEBOUNCE_CICLOS`=4.
- Reset, release all buttons for 4 cycles, `jogar_macro`=1, press bit 4 cleanly -> `tem_jogada` pulses once at press+7 cycles, `jogada`=4.
- Bounce: `botoes` toggles between 0x010 and 0x000 every 2 cycles, then holds 0x010 -> a single pulse 7 cycles after the final hold, `jogada`=4.
- Press 0x011 (two keys) with `jogar_micro`=1 -> `jogada_invalida` one-cycle pulse, `tem_jogada`=0, `jogada` unchanged.
- Hold bit 8 across the end of the macro window and into the micro window -> no pulse; release for 4 cycles, press bit 8 again -> pulse, `jogada`=8.
- Press bit 2 with `habilita`=0 -> no outputs. Then assert `zera` mid-`estabilizando` -> state 0 next cycle, `jogada`=0.
- Assert `reset_n`=0 in the `emite` cycle -> `tem_jogada` drops within the same cycle and `db_estado`=0.
